// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths and types for the register-file write-port arbiter.
// Consumers build in round-robin mode when RFARB_ROUND_ROBIN_EN is defined.
package rfarb_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_DW  = 32;
  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// One-hot grant generator for the write-port arbiter.
// RFARB_ROUND_ROBIN_EN selects round-robin with a pointer; otherwise fixed lowest-index priority.
module rr_arbiter
  import rfarb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PW = $clog2(MAX_REQ);

  logic [NUM_REQ-1:0] pick;
  logic               found;

`ifdef RFARB_ROUND_ROBIN_EN
  logic [PW-1:0]      ptr;
  logic [NUM_REQ-1:0] upper;

  // Requests at or above the pointer win first; wrap to the full set if none.
  always_comb begin
    upper = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      upper[i] = req[i] && (i >= 32'(ptr));
    pick = (|upper) ? upper : req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (gnt[i])
          ptr <= (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
  end
`else
  always_comb pick = req;
`endif

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (pick[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    if (reset || lock)
      gnt = '0;
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single regfile write port, with read forwarding.
// Build option: RFARB_ROUND_ROBIN_EN (round-robin grants; fixed priority when undefined).
module regfile_wr_arbiter
  import rfarb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned AW      = REG_AW,
  parameter int unsigned DW      = REG_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  lock,
  output logic                  we3,
  output logic [AW-1:0]         wa3,
  output logic [DW-1:0]         wd3,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DW-1:0]         fwd_data1,
  output logic [DW-1:0]         fwd_data2,
  output logic [2:0]            grant_id
);

  logic [NUM_REQ-1:0] gnt;
  logic               accept;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic [2:0]         sel_id;
  logic               stage_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .lock  (lock),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |(gnt & req_valid);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_id   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
        sel_id   = 3'(i);
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_vld <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      grant_id  <= '0;
    end else begin
      stage_vld <= accept;
      if (accept) begin
        wa3      <= sel_addr;
        wd3      <= sel_data;
        grant_id <= sel_id;
      end
    end
  end

  // r0 writes complete the handshake but never enable the port; reset drops the held write at once.
  assign we3 = stage_vld && (wa3 != AW'(REG_ZERO)) && !reset;

  always_comb begin
    fwd_hit1  = we3 && (wa3 == ra1) && (ra1 != AW'(REG_ZERO));
    fwd_hit2  = we3 && (wa3 == ra2) && (ra2 != AW'(REG_ZERO));
    fwd_data1 = fwd_hit1 ? wd3 : '0;
    fwd_data2 = fwd_hit2 ? wd3 : '0;
  end

endmodule
